// File: rtl/serial_addsub_ctrl_pkg.sv
// addsub_pkg: shared types and constants for the serial add/subtract sequencer.
//   state_e  : sequencer states (IDLE, RUN, DONE), 2-bit encoding
//   NIBBLE_W : width of the shared arithmetic slice
package addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_addsub_ctrl_nibble_addsub.sv
// nibble_addsub: combinational 4-bit add/subtract slice.
//   a, b : nibble operands
//   cin  : carry-in (inverted internally when sub=1)
//   sub  : 1 = a - b, 0 = a + b
//   s    : nibble sum/difference
//   cout : carry out of the nibble
module nibble_addsub
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W-1:0] b_eff;

  assign b_eff     = b ^ {NIBBLE_W{sub}};
  assign {cout, s} = {1'b0, a} + {1'b0, b_eff} + {{NIBBLE_W{1'b0}}, cin ^ sub};

endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: runs a WIDTH-bit add/subtract through a single 4-bit
// slice, one nibble per clock, LSB nibble first, with a registered carry.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   op_a, op_b          : operands
//   op_sub, op_cin      : 1 = A - B; carry-in (inverted when subtracting)
//   out_valid/out_ready : result handshake (valid only in DONE)
//   result, cout, ovf   : sum/difference, MSB carry, two's-complement overflow
module serial_addsub_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  input  logic             op_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  state_e             state_q,     state_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   a_sh_q,      a_sh_d;
  logic [WIDTH-1:0]   b_sh_q,      b_sh_d;     // already inverted for subtract
  logic               a_msb_q,     a_msb_d;
  logic               b_msb_q,     b_msb_d;    // MSB of effective B
  logic               carry_q,     carry_d;
  logic [IDX_W-1:0]   idx_q,       idx_d;
  logic [WIDTH-1:0]   result_q,    result_d;
  logic               cout_q,      cout_d;
  logic               ovf_q,       ovf_d;

  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_cout;
  logic                accept;
  logic                running;

  // B and carry-in are pre-inverted at capture, so the slice always adds.
  nibble_addsub u_slice (
    .a    (a_sh_q[NIBBLE_W-1:0]),
    .b    (b_sh_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .sub  (1'b0),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // in_ready_q stays low during reset and the first cycle after it, so it
  // gates acceptance in addition to the IDLE state.
  assign accept  = (state_q == IDLE) && in_ready_q && in_valid;
  assign running = (state_q == RUN);

  // Each result nibble is cleared on accept and written only in its own RUN cycle.
  for (genvar gi = 0; gi < NIB; gi++) begin : g_res_nib
    assign result_d[gi*NIBBLE_W +: NIBBLE_W] =
        accept                           ? '0      :
        (running && idx_q == IDX_W'(gi)) ? slice_s :
                                           result_q[gi*NIBBLE_W +: NIBBLE_W];
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_sh_d     = op_a;
          b_sh_d     = op_b ^ {WIDTH{op_sub}};
          a_msb_d    = op_a[WIDTH-1];
          b_msb_d    = op_b[WIDTH-1] ^ op_sub;
          carry_d    = op_cin ^ op_sub;
          idx_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      RUN: begin
        // Operands shift down so the slice always sees the current nibble at [3:0].
        a_sh_d  = a_sh_q >> NIBBLE_W;
        b_sh_d  = b_sh_q >> NIBBLE_W;
        carry_d = slice_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          idx_d       = '0;
          cout_d      = slice_cout;
          ovf_d       = (a_msb_q == b_msb_q) && (slice_s[NIBBLE_W-1] != a_msb_q);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
